// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding and fetch FSM states.
package cpu_pkg;

  localparam logic [3:0]  OPC_NOP   = 4'hE;
  localparam logic [3:0]  OPC_HALT  = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'hE000;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with reset, flush, load and hold.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned IW = 16,
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          flush,
  input  logic [IW-1:0] instr_in,
  input  logic [AW-1:0] pc1_in,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] pc1,
  output logic          valid
);

  localparam logic [IW-1:0] FLUSH_INSTR = {OPC_NOP, {(IW-4){1'b0}}};

  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] pc1_q, pc1_d;
  logic          valid_q, valid_d;

  // Next contents: flush beats load; neither means hold.
  always_comb begin
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = FLUSH_INSTR;
      pc1_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc1_d   = pc1_in;
      valid_d = 1'b1;
    end
  end

  // Register update with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= FLUSH_INSTR;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc1   = pc1_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, HALT freeze FSM, IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned    IW       = 16,
  parameter int unsigned    AW       = 16,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt_dec,
  output logic [IW-1:0] if_id_instr,
  output logic [AW-1:0] if_id_pc1,
  output logic          if_id_valid,
  output logic          halted
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          halted_q, halted_d;
  logic [AW-1:0] pc_plus1;
  logic          ifid_load;
  logic          ifid_flush;

  assign pc_plus1 = pc_q + AW'(1);

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FS_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Next state: a HALT in decode freezes fetch unless a redirect squashes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_RUN:    if (halt_dec && !redirect) state_d = FS_HALTED;
      FS_HALTED: state_d = FS_HALTED;
      default:   state_d = FS_RUN;
    endcase
  end

  // Outputs: next PC and IF/ID control, priority redirect > halt > stall > fetch.
  always_comb begin
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    halted_d   = (state_d == FS_HALTED);
    if (state_q == FS_RUN) begin
      if (redirect) begin
        pc_d       = redirect_pc;
        ifid_flush = 1'b1;
      end else if (halt_dec) begin
        ifid_flush = 1'b1;
      end else if (!stall) begin
        pc_d      = pc_plus1;
        ifid_load = 1'b1;
      end
    end
  end

  if_id_reg #(
    .IW (IW),
    .AW (AW)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (imem_data),
    .pc1_in   (pc_plus1),
    .instr    (if_id_instr),
    .pc1      (if_id_pc1),
    .valid    (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table followed by random stimulus against a model.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt_dec = 1'b0;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic        halted;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: word n holds 16'h4000 + n.
  function automatic logic [15:0] imem(input logic [15:0] a);
    return 16'h4000 + a;
  endfunction

  assign imem_data = imem(imem_addr);

  fetch_stage #(
    .IW       (16),
    .AW       (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_dec    (halt_dec),
    .if_id_instr (if_id_instr),
    .if_id_pc1   (if_id_pc1),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        halt;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_pc1;
    logic        e_valid;
    logic        e_halted;
    logic        chk_pc1;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic r, input logic s, input logic rd, input logic [15:0] rp,
                      input logic h, input logic [15:0] pc, input logic [15:0] ins,
                      input logic [15:0] p1, input logic v, input logic hl, input logic c1);
    vec_t t;
    t.rst = r; t.stall = s; t.redirect = rd; t.rpc = rp; t.halt = h;
    t.e_pc = pc; t.e_instr = ins; t.e_pc1 = p1; t.e_valid = v; t.e_halted = hl; t.chk_pc1 = c1;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs away from the clock edge, confirm imem_addr ignores them, then clock.
  task automatic drive(input logic r, input logic s, input logic rd, input logic [15:0] rp,
                       input logic h, input logic [15:0] pc_before, input logic chk_addr);
    rst = r; stall = s; redirect = rd; redirect_pc = rp; halt_dec = h;
    #1;
    if (chk_addr) chk("imem_addr_pre", imem_addr, pc_before);
    @(posedge clk);
    #1;
  endtask

  // Reference model state.
  logic [15:0] m_pc, m_instr, m_pc1;
  logic        m_valid, m_halted, m_pc1_known;

  task automatic model_step(input logic r, input logic s, input logic rd,
                            input logic [15:0] rp, input logic h);
    if (r) begin
      m_pc = 16'h0000; m_instr = NOP_INSTR; m_pc1 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_pc1_known = 1'b1;
    end else if (m_halted) begin
      // frozen until reset
    end else if (rd) begin
      m_pc = rp; m_instr = NOP_INSTR; m_valid = 1'b0; m_pc1_known = 1'b0;
    end else if (h) begin
      m_instr = NOP_INSTR; m_valid = 1'b0; m_halted = 1'b1; m_pc1_known = 1'b0;
    end else if (!s) begin
      m_instr = imem(m_pc); m_pc1 = m_pc + 16'd1; m_valid = 1'b1;
      m_pc = m_pc + 16'd1; m_pc1_known = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] prev_pc;
    logic        r, s, rd, h;
    logic [15:0] rp;

    // Reset, free run, two-cycle stall at pc=5, redirect with stall.
    push(1,0,0,16'h0000,0, 16'h0000,16'hE000,16'h0000,0,0,1);
    push(0,0,0,16'h0000,0, 16'h0001,16'h4000,16'h0001,1,0,1);
    push(0,0,0,16'h0000,0, 16'h0002,16'h4001,16'h0002,1,0,1);
    push(0,0,0,16'h0000,0, 16'h0003,16'h4002,16'h0003,1,0,1);
    push(0,0,0,16'h0000,0, 16'h0004,16'h4003,16'h0004,1,0,1);
    push(0,0,0,16'h0000,0, 16'h0005,16'h4004,16'h0005,1,0,1);
    push(0,1,0,16'h0000,0, 16'h0005,16'h4004,16'h0005,1,0,1);
    push(0,1,0,16'h0000,0, 16'h0005,16'h4004,16'h0005,1,0,1);
    push(0,0,0,16'h0000,0, 16'h0006,16'h4005,16'h0006,1,0,1);
    push(0,1,1,16'h0040,0, 16'h0040,16'hE000,16'h0000,0,0,0);
    push(0,0,0,16'h0000,0, 16'h0041,16'h4040,16'h0041,1,0,1);
    // HALT squashed by a simultaneous redirect.
    push(0,0,1,16'h0020,1, 16'h0020,16'hE000,16'h0000,0,0,0);
    push(0,0,0,16'h0000,0, 16'h0021,16'h4020,16'h0021,1,0,1);
    // PC wrap at all-ones, then reset during a stall.
    push(0,0,1,16'hFFFF,0, 16'hFFFF,16'hE000,16'h0000,0,0,0);
    push(0,0,0,16'h0000,0, 16'h0000,16'h3FFF,16'h0000,1,0,1);
    push(0,1,0,16'h0000,0, 16'h0000,16'h3FFF,16'h0000,1,0,1);
    push(1,1,0,16'h0000,0, 16'h0000,16'hE000,16'h0000,0,0,1);
    // Run to pc=9, HALT, ten frozen cycles with redirect pulses, then reset.
    for (int unsigned i = 1; i <= 9; i++)
      push(0,0,0,16'h0000,0, 16'(i),16'(16'h4000 + i - 1),16'(i),1,0,1);
    push(0,0,0,16'h0000,1, 16'h0009,16'hE000,16'h0000,0,1,0);
    for (int unsigned i = 0; i < 10; i++)
      push(0,i[1],i[0],16'h0077,i[2], 16'h0009,16'hE000,16'h0000,0,1,0);
    push(1,0,0,16'h0000,0, 16'h0000,16'hE000,16'h0000,0,0,1);

    @(negedge clk);
    prev_pc = 16'h0000;
    for (int unsigned k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].stall, vecs[k].redirect, vecs[k].rpc, vecs[k].halt,
            prev_pc, k != 0);
      chk("v_pc", imem_addr, vecs[k].e_pc);
      chk("v_instr", if_id_instr, vecs[k].e_instr);
      chk("v_valid", {15'b0, if_id_valid}, {15'b0, vecs[k].e_valid});
      chk("v_halted", {15'b0, halted}, {15'b0, vecs[k].e_halted});
      if (vecs[k].chk_pc1) chk("v_pc1", if_id_pc1, vecs[k].e_pc1);
      prev_pc = vecs[k].e_pc;
    end

    // Random phase; DUT was just reset, so start the model from reset too.
    model_step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int unsigned k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 19) == 0);
      rp = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      prev_pc = m_pc;
      model_step(r, s, rd, rp, h);
      drive(r, s, rd, rp, h, prev_pc, 1'b1);
      chk("r_pc", imem_addr, m_pc);
      chk("r_instr", if_id_instr, m_instr);
      chk("r_valid", {15'b0, if_id_valid}, {15'b0, m_valid});
      chk("r_halted", {15'b0, halted}, {15'b0, m_halted});
      if (m_pc1_known) chk("r_pc1", if_id_pc1, m_pc1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
